spart_tx: RTL and testbench

Serial transmitter for the SPART. Accepts a byte from the driver over an 8-bit parallel interface, holds it in a one-byte holding register, and shifts it out LSB-first on `txd` as an 8N1 frame (start bit, 8 data bits, stop bit). It is paced by the baud-rate generator's `tx_enable` tick. It sits beside the SPART receiver and supplies the line-side output of the same UART link.

---
 rtl/spart_tx_if.sv | 24 ++
 rtl/spart_tx.sv | 171 +++++++++++++++++
 tb/tb_spart_tx.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/spart_tx_if.sv
// Driver-side parallel bus of the SPART transmitter: write strobe, byte,
// buffer-ready status and the sticky overrun flag.
interface spart_tx_if;
  logic       write;
  logic [7:0] tx_data;
  logic       tbr;
  logic       tx_overrun;

  // A write is taken on a clk edge where write=1 and tbr=1. A write while
  // tbr=0 is dropped and sets tx_overrun. There is no back-pressure beyond tbr.
  modport master (
    output write,
    output tx_data,
    input  tbr,
    input  tx_overrun
  );

  modport slave (
    input  write,
    input  tx_data,
    output tbr,
    output tx_overrun
  );
endinterface

// File: rtl/spart_tx.sv
// SPART serial transmitter: one-byte holding register feeding an 8N1 shifter
// paced by tx_enable. Define SPART_TX_PARITY_EN for an even-parity bit (8E1).
module spart_tx #(
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_enable,
  spart_tx_if.slave  bus,
  output logic       txd,
  output logic       tx_busy,
  output logic [2:0] dbg_state
);

`ifdef SPART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);

  state_t     state, state_d;
  logic [7:0] hold;
  logic       hold_full, hold_full_d;
  logic [7:0] shift, shift_d;
  logic [3:0] tick, tick_d;
  logic [2:0] bidx, bidx_d;
  logic       txd_q, txd_d;
  logic       overrun_q;
  logic       transfer;
  logic       bit_end;
  logic       accept;
`ifdef SPART_TX_PARITY_EN
  logic       par_q, par_d;
`endif

  assign bit_end = tx_enable && (tick == TICK_LAST);
  assign accept  = bus.write && !hold_full;

  always_comb begin
    state_d  = state;
    tick_d   = tick;
    bidx_d   = bidx;
    shift_d  = shift;
    transfer = 1'b0;

    // The tick counter only advances on baud ticks and wraps at bit end.
    if (state != ST_IDLE && tx_enable) begin
      tick_d = bit_end ? 4'd0 : tick + 4'd1;
    end

    case (state)
      ST_IDLE: begin
        if (hold_full) begin
          transfer = 1'b1;
          state_d  = ST_START;
          tick_d   = 4'd0;
          bidx_d   = 3'd0;
        end
      end
      ST_START: begin
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (bit_end) begin
          shift_d = {1'b0, shift[7:1]};
          bidx_d  = bidx + 3'd1;
          if (bidx == 3'd7) begin
`ifdef SPART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end
        end
      end
`ifdef SPART_TX_PARITY_EN
      ST_PARITY: begin
        if (bit_end) state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        if (bit_end) begin
          // A byte already waiting starts immediately, with no idle gap.
          if (hold_full) begin
            transfer = 1'b1;
            state_d  = ST_START;
            bidx_d   = 3'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (transfer) shift_d = hold;
  end

  always_comb begin
    hold_full_d = hold_full;
    if (transfer)    hold_full_d = 1'b0;
    else if (accept) hold_full_d = 1'b1;
  end

`ifdef SPART_TX_PARITY_EN
  assign par_d = transfer ? ^hold : par_q;
`endif

  // txd is registered from the next state so the line moves on the same
  // edge as the state change and never sees a combinational input path.
  always_comb begin
    txd_d = 1'b1;
    case (state_d)
      ST_START:  txd_d = 1'b0;
      ST_DATA:   txd_d = shift_d[0];
`ifdef SPART_TX_PARITY_EN
      ST_PARITY: txd_d = par_d;
`endif
      default:   txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      shift     <= 8'h00;
      tick      <= 4'd0;
      bidx      <= 3'd0;
      txd_q     <= 1'b1;
      overrun_q <= 1'b0;
    end else begin
      state     <= state_d;
      hold_full <= hold_full_d;
      shift     <= shift_d;
      tick      <= tick_d;
      bidx      <= bidx_d;
      txd_q     <= txd_d;
      if (accept) hold <= bus.tx_data;
      if (bus.write && hold_full) overrun_q <= 1'b1;
    end
  end

`ifdef SPART_TX_PARITY_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) par_q <= 1'b0;
    else     par_q <= par_d;
  end
`endif

  assign txd            = txd_q;
  assign tx_busy        = (state != ST_IDLE);
  assign bus.tbr        = !hold_full;
  assign bus.tx_overrun = overrun_q;
  assign dbg_state      = state;

endmodule

// File: tb/tb_spart_tx.sv
// Directed bench for spart_tx: frames are decoded tick by tick against an
// expected-byte queue; tx_enable pulses every 4th clk cycle.
module tb_spart_tx;
  localparam int OS = 16;
`ifdef SPART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk;
  logic       rst;
  logic       tx_enable;
  logic       txd;
  logic       tx_busy;
  logic [2:0] dbg_state;
  bit         te_gate = 1'b1;
  logic [1:0] te_cnt;

  logic [7:0] exp_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  spart_tx_if bus ();

  spart_tx #(.OVERSAMPLE(OS)) dut (
    .clk       (clk),
    .rst       (rst),
    .tx_enable (tx_enable),
    .bus       (bus),
    .txd       (txd),
    .tx_busy   (tx_busy),
    .dbg_state (dbg_state)
  );

  // clock / reset / baud tick
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tx_enable = 1'b0;
    te_cnt    = 2'd0;
    forever begin
      @(negedge clk);
      te_cnt    = te_cnt + 2'd1;
      tx_enable = te_gate && (te_cnt == 2'd3);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_bit(input logic [7:0] d, input int b);
    if (b == 0) return 1'b0;
    if (b <= 8) return d[b-1];
`ifdef SPART_TX_PARITY_EN
    if (b == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  // driver
  task automatic do_write(input logic [7:0] d);
    @(negedge clk);
    bus.write   = 1'b1;
    bus.tx_data = d;
    @(negedge clk);
    bus.write   = 1'b0;
    bus.tx_data = 8'h00;
  endtask

  task automatic wait_tbr(input string tag);
    int n;
    n = 0;
    while (bus.tbr !== 1'b1 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(tag, bus.tbr, 1'b1);
  endtask

  // Decode one frame: boundary and mid-bit samples counted in consumed ticks.
  task automatic rx_frame(input string tag, input bit chained, input int gate_at);
    logic [7:0] d;
    int         k, n;
    logic       held;
    bit         ok;
    check({tag, "_queue"}, (exp_q.size() != 0), 1);
    if (exp_q.size() == 0) return;
    d = exp_q.pop_front();
    n = 0;
    while (txd !== 1'b0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_start"}, txd, 1'b0);
    k = 0;
    n = 0;
    while (k < OS * NB && n < 3000) begin
      @(posedge clk); #1;
      n++;
      if (tx_enable) begin
        k++;
        if (k % OS == 0 && k < OS * NB)
          check($sformatf("%s_edge%0d", tag, k / OS), txd, exp_bit(d, k / OS));
        if (k % OS == OS / 2)
          check($sformatf("%s_mid%0d", tag, k / OS), txd, exp_bit(d, k / OS));
        if (k == gate_at) begin
          held    = txd;
          ok      = 1'b1;
          te_gate = 1'b0;
          repeat (100) begin
            @(posedge clk); #1;
            if (txd !== held || tx_enable !== 1'b0 || tx_busy !== 1'b1) ok = 1'b0;
          end
          te_gate = 1'b1;
          check({tag, "_gate_hold"}, ok, 1'b1);
        end
      end
    end
    check({tag, "_ticks"}, k, OS * NB);
    if (chained) begin
      check({tag, "_next_start"}, txd, 1'b0);
      check({tag, "_next_busy"}, tx_busy, 1'b1);
      check({tag, "_next_tbr"}, bus.tbr, 1'b1);
    end else begin
      check({tag, "_end_txd"}, txd, 1'b1);
      check({tag, "_end_busy"}, tx_busy, 1'b0);
    end
  endtask

  initial begin
    int k, n;
    rst         = 1'b1;
    bus.write   = 1'b0;
    bus.tx_data = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_txd", txd, 1'b1);
    check("rst_tbr", bus.tbr, 1'b1);
    check("rst_busy", tx_busy, 1'b0);
    check("rst_ovr", bus.tx_overrun, 1'b0);
    check("rst_state", dbg_state, 3'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("idle_txd", txd, 1'b1);

    // single byte 0x55 with latency checks
    exp_q.push_back(8'h55);
    do_write(8'h55);
    check("lat_tbr_n", bus.tbr, 1'b0);
    check("lat_txd_n", txd, 1'b1);
    @(negedge clk);
    check("lat_txd_n1", txd, 1'b0);
    check("lat_tbr_n1", bus.tbr, 1'b1);
    check("lat_busy_n1", tx_busy, 1'b1);
    rx_frame("b55", 0, 0);

    // back-to-back 0xA3 then 0x0F
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h0F);
    do_write(8'hA3);
    fork
      rx_frame("bA3", 1, 0);
      begin
        wait_tbr("b2b_tbr_free");
        do_write(8'h0F);
        check("b2b_tbr_held", bus.tbr, 1'b0);
        repeat (200) @(negedge clk);
        check("b2b_tbr_still", bus.tbr, 1'b0);
      end
    join
    rx_frame("b0F", 0, 0);

    // overrun: 0x33 dropped
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    do_write(8'h11);
    check("ovr_tbr0", bus.tbr, 1'b0);
    wait_tbr("ovr_tbr_free");
    do_write(8'h22);
    check("ovr_tbr_held", bus.tbr, 1'b0);
    check("ovr_flag0", bus.tx_overrun, 1'b0);
    do_write(8'h33);
    check("ovr_flag1", bus.tx_overrun, 1'b1);
    rx_frame("o11", 1, 0);
    rx_frame("o22", 0, 0);
    repeat (100) @(negedge clk);
    check("ovr_after_busy", tx_busy, 1'b0);
    check("ovr_sticky", bus.tx_overrun, 1'b1);

    // tick gating in the middle of data bit 2
    exp_q.push_back(8'hC5);
    do_write(8'hC5);
    rx_frame("gC5", 0, 3 * OS + 5);

    // reset mid-frame, with a second byte held
    do_write(8'hFF);
    wait_tbr("rst_tbr_free");
    do_write(8'hEE);
    n = 0;
    while (txd !== 1'b0 && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    k = 0;
    while (k < 4 * OS + OS / 2 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (tx_enable) k++;
    end
    @(negedge clk);
    check("prerst_busy", tx_busy, 1'b1);
    check("prerst_tbr", bus.tbr, 1'b0);
    rst = 1'b1;
    #1;
    check("midrst_txd", txd, 1'b1);
    check("midrst_tbr", bus.tbr, 1'b1);
    check("midrst_busy", tx_busy, 1'b0);
    check("midrst_ovr", bus.tx_overrun, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(8'h00);
    do_write(8'h00);
    rx_frame("r00", 0, 0);
    repeat (50) @(negedge clk);
    check("r00_quiet_busy", tx_busy, 1'b0);
    check("r00_quiet_txd", txd, 1'b1);

    // parity patterns (plain 8N1 frames when parity is disabled)
    exp_q.push_back(8'h07);
    do_write(8'h07);
    rx_frame("p07", 0, 0);
    exp_q.push_back(8'h03);
    do_write(8'h03);
    rx_frame("p03", 0, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
